// File: rtl/athena_pkg.sv
// Shared constants and types for the Athena hi-score save path.
// Side RAM bus layout as seen on the game CPU's monitor tap.
package athena_pkg;

  localparam logic [15:0] HISCORE_SLOT_ID    = 16'd2;
  localparam logic [31:0] HISCORE_START      = 32'h2000_0000;
  localparam logic [10:0] HISCORE_FIRST_ADDR = 11'h650;
  localparam logic [10:0] HISCORE_LAST_ADDR  = 11'h6c1;
  localparam logic [31:0] HISCORE_SIZE       = 32'd114;

  typedef struct packed {
    logic        n_cs;
    logic        n_we;
    logic        n_oe;
    logic [15:0] addr;
    logic [7:0]  data;
  } side_ram_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAN   = 3'd1,
    DIRTY   = 3'd2,
    PAUSE   = 3'd3,
    WRITE   = 3'd4,
    RELEASE = 3'd5
  } hs_save_state_e;

  function automatic logic in_window(input logic [10:0] addr,
                                     input logic [10:0] first,
                                     input logic [10:0] last);
    return (addr >= first) && (addr <= last);
  endfunction

endpackage

// File: rtl/athena_quiet_timer.sv
// Reloadable down-counter; expired while the count sits at zero.
// Decrement saturates at zero so a late dec never wraps the count.
module athena_quiet_timer #(
  parameter int W = 24
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_value_i,
  output logic         expired_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/athena_hiscore_save.sv
// Hi-score write-back: watches game writes to the table, and after a quiet
// period pauses the CPU and requests a dataslot write so the host saves it.
module athena_hiscore_save
  import athena_pkg::*;
#(
  parameter logic [15:0] SLOT_ID      = HISCORE_SLOT_ID,
  parameter logic [31:0] BRIDGE_ADDR  = HISCORE_START,
  parameter logic [31:0] LENGTH       = HISCORE_SIZE,
  parameter logic [10:0] HS_FIRST     = HISCORE_FIRST_ADDR,
  parameter logic [10:0] HS_LAST      = HISCORE_LAST_ADDR,
  parameter logic [23:0] QUIET_CYCLES = 24'd2_000_000
) (
  input  logic        game_clk,
  input  logic        reset,
  input  side_ram_t   side_ram_monitor,
  input  logic        restore_done,
  input  logic        pause_cpu,
  output logic        hs_pause_req,
  output logic        wr_valid,
  output logic [15:0] wr_slot_id,
  output logic [31:0] wr_slot_offset,
  output logic [31:0] wr_bridge_addr,
  output logic [31:0] wr_length,
  input  logic        wr_done,
  output logic [7:0]  save_count
);

  hs_save_state_e state_q, state_d;
  logic           redirty_q, redirty_d;
  logic [7:0]     save_count_q, save_count_d;
  logic           qual_wr;
  logic           tmr_load, tmr_dec, tmr_expired;
  logic           unused_bus;

  // Writes while the bridge owns the bus are not the game's and never count.
  assign qual_wr = ~side_ram_monitor.n_cs & ~side_ram_monitor.n_we & ~pause_cpu &
                   in_window(side_ram_monitor.addr[10:0], HS_FIRST, HS_LAST);

  assign unused_bus = ^{side_ram_monitor.n_oe, side_ram_monitor.addr[15:11],
                        side_ram_monitor.data};

  athena_quiet_timer #(
    .W(24)
  ) u_quiet_timer (
    .clk_i       (game_clk),
    .rst_i       (reset),
    .load_i      (tmr_load),
    .dec_i       (tmr_dec),
    .load_value_i(QUIET_CYCLES - 24'd1),
    .expired_o   (tmr_expired)
  );

  always_comb begin
    state_d      = state_q;
    redirty_d    = redirty_q;
    save_count_d = save_count_q;
    tmr_load     = 1'b0;
    tmr_dec      = 1'b0;
    hs_pause_req = 1'b0;
    wr_valid     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (restore_done) begin
          state_d = CLEAN;
        end
      end
      CLEAN: begin
        if (qual_wr) begin
          state_d  = DIRTY;
          tmr_load = 1'b1;
        end
      end
      DIRTY: begin
        if (qual_wr) begin
          tmr_load = 1'b1;
        end else if (tmr_expired) begin
          state_d = PAUSE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      PAUSE: begin
        hs_pause_req = 1'b1;
        if (qual_wr) begin
          redirty_d = 1'b1;
        end
        if (pause_cpu) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        hs_pause_req = 1'b1;
        wr_valid     = 1'b1;
        if (wr_done) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        save_count_d = save_count_q + 8'd1;
        redirty_d    = 1'b0;
        // A write that slipped in before the halt means the saved copy is stale.
        if (redirty_q) begin
          state_d  = DIRTY;
          tmr_load = 1'b1;
        end else begin
          state_d = CLEAN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge game_clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      redirty_q    <= 1'b0;
      save_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      redirty_q    <= redirty_d;
      save_count_q <= save_count_d;
    end
  end

  assign save_count     = save_count_q;
  assign wr_slot_id     = SLOT_ID;
  assign wr_slot_offset = 32'd0;
  assign wr_bridge_addr = BRIDGE_ADDR;
  assign wr_length      = LENGTH;

endmodule

// File: tb/tb_athena_hiscore_save.sv
// Randomized bench for athena_hiscore_save: the driver predicts event timing
// from the quiet-period rules and a monitor checks what the DUT presents.
module tb_athena_hiscore_save;
  import athena_pkg::*;

  localparam int          Q       = 16;
  localparam logic [15:0] T_SLOT  = 16'h00a7;
  localparam logic [31:0] T_BADDR = 32'h3000_0100;
  localparam logic [31:0] T_LEN   = 32'd114;

  logic        clk = 1'b0;
  logic        rst;
  side_ram_t   bus;
  logic        restore_done, pause_cpu, wr_done;
  logic        hs_pause_req, wr_valid;
  logic [15:0] wr_slot_id;
  logic [31:0] wr_slot_offset, wr_bridge_addr, wr_length;
  logic [7:0]  save_count;

  athena_hiscore_save #(
    .SLOT_ID(T_SLOT), .BRIDGE_ADDR(T_BADDR), .LENGTH(T_LEN),
    .HS_FIRST(11'h650), .HS_LAST(11'h6c1), .QUIET_CYCLES(24'(Q))
  ) dut (
    .game_clk(clk), .reset(rst), .side_ram_monitor(bus),
    .restore_done(restore_done), .pause_cpu(pause_cpu),
    .hs_pause_req(hs_pause_req), .wr_valid(wr_valid),
    .wr_slot_id(wr_slot_id), .wr_slot_offset(wr_slot_offset),
    .wr_bridge_addr(wr_bridge_addr), .wr_length(wr_length),
    .wr_done(wr_done), .save_count(save_count)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_PAUSE = 0, EV_VALID = 1, EV_COUNT = 2} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       val;
  } ev_t;

  ev_t sbq[$];
  int  n_chk = 0;
  int  n_pass = 0;
  int  cyc = 0;
  int  model_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endfunction

  function automatic void push(input ev_kind_e k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    sbq.push_back(e);
  endfunction

  function automatic void expect_ev(input ev_kind_e k, input int act, input string nm);
    ev_t e;
    if (sbq.size() == 0) begin
      n_chk++;
      $display("FAIL %s: unexpected event value %0d at cycle %0d, none expected", nm, act, cyc);
    end else begin
      e = sbq.pop_front();
      check({nm, "_kind"}, longint'(k), longint'(e.kind));
      check(nm, act, e.val);
    end
  endfunction

  // Monitor: reacts to DUT output events, independent of the driver.
  logic prev_req = 1'b0, prev_valid = 1'b0;
  logic [7:0] prev_cnt = 8'd0;
  int vstart = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (hs_pause_req && !prev_req) expect_ev(EV_PAUSE, cyc, "pause_rise_cycle");
      if (wr_valid && !prev_valid) begin
        vstart = cyc;
        check("wr_slot_id", wr_slot_id, T_SLOT);
        check("wr_slot_offset", wr_slot_offset, 0);
        check("wr_bridge_addr", wr_bridge_addr, T_BADDR);
        check("wr_length", wr_length, T_LEN);
        check("req_during_write", hs_pause_req, 1);
      end
      if (!wr_valid && prev_valid) expect_ev(EV_VALID, cyc - vstart, "wr_valid_len");
      if (save_count != prev_cnt) expect_ev(EV_COUNT, int'(save_count), "save_count");
    end
    prev_req   = hs_pause_req;
    prev_valid = wr_valid;
    prev_cnt   = save_count;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.n_cs = 1'b1; bus.n_we = 1'b1; bus.n_oe = 1'b1;
    bus.addr = 16'd0; bus.data = 8'd0;
  endtask

  task automatic bus_write(input logic [10:0] a);
    bus.n_cs = 1'b0; bus.n_we = 1'b0; bus.n_oe = 1'b1;
    bus.addr = {5'd0, a}; bus.data = 8'($urandom);
  endtask

  task automatic nonqual();
    case ($urandom_range(0, 3))
      0: bus_write(11'h64f);
      1: bus_write(11'h6c2);
      2: begin bus_write(11'h680); bus.n_we = 1'b1; end
      default: bus_write(11'h100);
    endcase
  endtask

  // Qualifying writes with gaps <= Q; save expected Q+1 cycles after the last.
  task automatic burst(input int n, input int gap, input logic [10:0] fixed_addr, input bit use_fixed);
    int last;
    int g;
    logic [10:0] a;
    last = 0;
    for (int i = 0; i < n; i++) begin
      if (use_fixed) a = fixed_addr;
      else case ($urandom_range(0, 3))
        0: a = 11'h650;
        1: a = 11'h6c1;
        default: a = 11'($urandom_range(32'h650, 32'h6c1));
      endcase
      bus_write(a);
      last = cyc;
      tick();
      bus_idle();
      if (i < n - 1) begin
        g = (gap > 0) ? gap : int'($urandom_range(1, Q));
        for (int j = 1; j < g; j++) begin
          if ($urandom_range(0, 2) == 0) nonqual();
          tick();
          bus_idle();
        end
      end
    end
    push(EV_PAUSE, last + Q + 1);
  endtask

  task automatic wait_pause();
    int k;
    k = 0;
    while (!hs_pause_req && k < Q + 40) begin
      tick();
      k++;
    end
    if (!hs_pause_req) begin
      n_chk++;
      $display("FAIL pause_wait: hs_pause_req still 0 after %0d cycles (cycle %0d)", k, cyc);
    end
  endtask

  // kind 1: stray game write into the table while paused -> another save.
  // kind 2: write just past the table plus an early wr_done -> both ignored.
  task automatic serve(input int delay, input int len, input int kind);
    for (int i = 0; i < delay; i++) begin
      if (i == 0 && kind == 1) bus_write(11'h6c1);
      if (i == 0 && kind == 2) begin bus_write(11'h6c2); wr_done = 1'b1; end
      tick();
      bus_idle();
      wr_done = 1'b0;
    end
    pause_cpu = 1'b1;
    push(EV_VALID, len);
    repeat (len) tick();
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    model_count = (model_count + 1) % 256;
    push(EV_COUNT, model_count);
    tick();
    pause_cpu = 1'b0;
    if (kind == 1 && delay > 0) push(EV_PAUSE, cyc + Q);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    rst = 1'b1; restore_done = 1'b0; pause_cpu = 1'b0; wr_done = 1'b0;
    bus_idle();
    repeat (3) tick();
    check("reset_pause_req", hs_pause_req, 0);
    check("reset_wr_valid", wr_valid, 0);
    check("reset_save_count", save_count, 0);
    check("reset_wr_slot_id", wr_slot_id, T_SLOT);
    check("reset_wr_length", wr_length, T_LEN);
    rst = 1'b0;
    tick();

    // Restore traffic before restore_done must not arm a save.
    bus_write(11'h6c0);
    bus.data = 8'h30;
    tick();
    bus_idle();
    repeat (40) tick();
    check("idle_no_pause", hs_pause_req, 0);

    restore_done = 1'b1;
    tick();
    tick();

    for (int r = 0; r < 10; r++) begin
      if (r == 5) restore_done = 1'b0;
      if (r == 0) burst(1, 0, 11'h650, 1'b1);
      else if (r == 1) burst(5, 10, 11'h660, 1'b1);
      else burst(int'($urandom_range(1, 5)), 0, 11'h0, 1'b0);
      wait_pause();
      kind = (r == 0) ? 0 : (r % 3);
      if (r == 0) serve(5, 20, 0);
      else serve(int'($urandom_range(1, 6)), int'($urandom_range(1, 24)), kind);
      if (kind == 1) begin
        wait_pause();
        serve(int'($urandom_range(0, 4)), int'($urandom_range(1, 8)), 0);
      end
      repeat ($urandom_range(1, 5)) tick();
    end

    // Reset in the middle of a write-back.
    burst(2, 0, 11'h0, 1'b0);
    wait_pause();
    pause_cpu = 1'b1;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("rst_mid_write_valid", wr_valid, 0);
    check("rst_mid_write_req", hs_pause_req, 0);
    check("rst_mid_write_count", save_count, 0);
    model_count = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    pause_cpu = 1'b0;
    tick();
    check("post_reset_valid", wr_valid, 0);

    // restore_done is low, so the block must sit in IDLE.
    bus_write(11'h650);
    tick();
    bus_idle();
    repeat (30) tick();
    check("post_reset_idle_no_pause", hs_pause_req, 0);

    restore_done = 1'b1;
    tick();
    tick();
    burst(3, 0, 11'h0, 1'b0);
    wait_pause();
    serve(5, 20, 0);
    repeat (5) tick();
    check("scoreboard_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
